seq_signed_multiplier: RTL and testbench

//   Iterative two's-complement/unsigned multiplier with valid/ready handshakes.

---
 rtl/seq_signed_multiplier.sv | 82 ++++++++
 tb/tb_seq_signed_multiplier.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier: iterative signed/unsigned multiply-accumulate, R multiplier bits per cycle
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b                : multiplicand, multiplier (W bits)
//   is_signed, acc      : two's-complement operands; add product to previous p
//   out_valid/out_ready : result handshake (valid only in DONE)
//   p                   : 2W-bit product or accumulated sum, mod 2^(2W)
//   busy                : high in RUN or DONE
module seq_signed_multiplier #(
  parameter int W = 4,
  parameter int R = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  input  logic           acc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);
  localparam int N  = W / R;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_state, w_next;
  logic [2*W-1:0] r_mcand, r_sum, r_p;
  logic [2*W-1:0] w_a_ext, w_mcand, w_term;
  logic [W-1:0]   r_mplier, w_mplier;
  logic [CW-1:0]  r_cnt;
  logic           w_neg, w_accept, w_last;
  // A negative multiplier is handled by negating both operands; the 2W-bit
  // extension keeps -2^(W-1) exact, and the negated b is read as unsigned.
  assign w_a_ext  = {{W{is_signed & a[W-1]}}, a};
  assign w_neg    = is_signed & b[W-1];
  assign w_mcand  = w_neg ? -w_a_ext : w_a_ext;
  assign w_mplier = w_neg ? -b : b;
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = r_cnt == CW'(N - 1);
  // The multiplicand is pre-shifted each cycle, so the digit product needs no variable shift.
  assign w_term   = r_mcand * {{(2*W-R){1'b0}}, r_mplier[R-1:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sum    <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mcand  <= w_mcand;
        r_mplier <= w_mplier;
        r_sum    <= acc ? r_p : '0;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        r_sum    <= r_sum + w_term;
        r_mcand  <= r_mcand << R;
        r_mplier <= r_mplier >> R;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) r_p <= r_sum + w_term;
      end
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign p         = r_p;
endmodule

// File: tb/tb_seq_signed_multiplier.sv
// tb_seq_signed_multiplier: scoreboard bench for W=4,R=1 and W=8,R=2 instances
module tb_seq_signed_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       iv0 = 0, ir0, s0 = 0, ac0 = 0, ov0, or0 = 1, busy0;
  logic [3:0] a0 = 0, b0 = 0;
  logic [7:0] p0;
  logic       iv1 = 0, ir1, s1 = 0, ac1 = 0, ov1, or1 = 1, busy1;
  logic [7:0] a1 = 0, b1 = 0;
  logic [15:0] p1;
  seq_signed_multiplier #(.W(4), .R(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .is_signed(s0), .acc(ac0), .out_valid(ov0), .out_ready(or0), .p(p0), .busy(busy0));
  seq_signed_multiplier #(.W(8), .R(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .is_signed(s1), .acc(ac1), .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1));
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] m_p[2];
  logic [15:0] last_e[2];
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Plain integer arithmetic: interpret operands, multiply, add, wrap.
  function automatic logic [15:0] model(int w, logic [7:0] x, logic [7:0] y,
                                        logic s, logic ac, logic [15:0] prev);
    longint xa = longint'(x);
    longint ya = longint'(y);
    longint r;
    if (s && x[w-1]) xa -= longint'(1) << w;
    if (s && y[w-1]) ya -= longint'(1) << w;
    r = xa * ya + (ac ? longint'(prev) : 64'sd0);
    return 16'(r & ((longint'(1) << (2 * w)) - 1));
  endfunction
  function automatic logic [15:0] get_p(int wh);
    return wh != 0 ? p1 : {8'h00, p0};
  endfunction
  function automatic logic get_ov(int wh);
    return wh != 0 ? ov1 : ov0;
  endfunction
  function automatic logic get_ir(int wh);
    return wh != 0 ? ir1 : ir0;
  endfunction
  function automatic logic get_busy(int wh);
    return wh != 0 ? busy1 : busy0;
  endfunction
  task automatic set_in(int wh, logic [7:0] x, logic [7:0] y, logic s, logic ac, logic v);
    if (wh == 0) begin
      a0 = x[3:0]; b0 = y[3:0]; s0 = s; ac0 = ac; iv0 = v;
    end else begin
      a1 = x; b1 = y; s1 = s; ac1 = ac; iv1 = v;
    end
  endtask
  task automatic set_ordy(int wh, logic v);
    if (wh == 0) or0 = v;
    else or1 = v;
  endtask
  always @(negedge clk) begin
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon0_unexpected: got %h expected no result", p0);
      end else chk("mon0_p", {8'h00, p0}, q0.pop_front());
    end
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon1_unexpected: got %h expected no result", p1);
      end else chk("mon1_p", p1, q1.pop_front());
    end
  end
  task automatic issue(int wh, logic [7:0] x, logic [7:0] y, logic s, logic ac, logic ordy);
    int n = 0;
    logic [15:0] e;
    if (wh == 0) begin
      x &= 8'h0F; y &= 8'h0F;
    end
    @(negedge clk);
    while (!get_ir(wh) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 16'd0, 16'd1);
    e = model(wh != 0 ? 8 : 4, x, y, s, ac, m_p[wh]);
    m_p[wh] = e;
    last_e[wh] = e;
    if (wh == 0) q0.push_back(e);
    else q1.push_back(e);
    set_in(wh, x, y, s, ac, 1'b1);
    set_ordy(wh, ordy);
    @(posedge clk);
    #1;
    set_in(wh, x, y, s, ac, 1'b0);
  endtask
  task automatic wait_done(int wh, int hold);
    int n = 0;
    while (!get_ov(wh) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 16'(n), 16'd4);
    chk("busy_done", {15'd0, get_busy(wh)}, 16'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_p", get_p(wh), last_e[wh]);
      chk("hold_ov", {15'd0, get_ov(wh)}, 16'd1);
      chk("hold_ir", {15'd0, get_ir(wh)}, 16'd0);
      @(posedge clk);
      #1;
      set_in(wh, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    set_in(wh, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    set_ordy(wh, 1'b1);
    @(posedge clk);
    #1;
    chk("ir_after", {15'd0, get_ir(wh)}, 16'd1);
    chk("ov_after", {15'd0, get_ov(wh)}, 16'd0);
    chk("p_keep", get_p(wh), last_e[wh]);
  endtask
  task automatic op(int wh, logic [7:0] x, logic [7:0] y, logic s, logic ac, logic [15:0] lit);
    issue(wh, x, y, s, ac, 1'b1);
    wait_done(wh, 0);
    chk("literal", get_p(wh), lit);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    m_p[0] = '0; m_p[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_p", get_p(k), 16'd0);
      chk("rst_ov", {15'd0, get_ov(k)}, 16'd0);
      chk("rst_ir", {15'd0, get_ir(k)}, 16'd1);
      chk("rst_busy", {15'd0, get_busy(k)}, 16'd0);
    end
    op(0, 8'd15, 8'd15, 1'b0, 1'b0, 16'h00E1);
    op(0, 8'h8, 8'h8, 1'b1, 1'b0, 16'h0040);
    op(0, 8'h8, 8'h7, 1'b1, 1'b0, 16'h00C8);
    op(0, 8'h7, 8'hF, 1'b1, 1'b0, 16'h00F9);
    issue(0, 8'd5, 8'd3, 1'b0, 1'b0, 1'b0);
    wait_done(0, 5);
    chk("hold_literal", get_p(0), 16'h000F);
    op(0, 8'd3, 8'd5, 1'b0, 1'b0, 16'h000F);
    op(0, 8'd2, 8'hF, 1'b1, 1'b1, 16'h000D);
    op(0, 8'd1, 8'hF, 1'b1, 1'b0, 16'h00FF);
    op(0, 8'd1, 8'd1, 1'b0, 1'b1, 16'h0000);
    op(0, 8'd9, 8'd9, 1'b0, 1'b0, 16'h0051);
    issue(0, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(q0.pop_back());
    m_p[0] = '0;
    @(negedge clk);
    chk("midrun_rst_ov", {15'd0, ov0}, 16'd0);
    chk("midrun_rst_p", {8'h00, p0}, 16'd0);
    chk("midrun_rst_ir", {15'd0, ir0}, 16'd1);
    op(0, 8'd6, 8'd7, 1'b0, 1'b1, 16'h002A);
    op(1, 8'd127, 8'd128, 1'b1, 1'b0, 16'hC080);
    op(1, 8'd255, 8'd255, 1'b0, 1'b0, 16'hFE01);
    op(1, 8'd128, 8'd128, 1'b1, 1'b0, 16'h4000);
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2; k++) begin
        int h = $urandom_range(0, 3);
        issue(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), h == 0);
        wait_done(k, h);
      end
    end
    repeat (2) @(negedge clk);
    chk("q0_drained", 16'(q0.size()), 16'd0);
    chk("q1_drained", 16'(q1.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
